// File: rtl/uart_tx_serializer_pkg.sv
// Shared types and constants for the UART transmit serializer.
// The optional line-break feature is selected with UART_TX_BREAK_EN.
package uart_tx_serializer_pkg;

    localparam int UART_DATA_BITS     = 8;
    localparam int UART_DIV_W         = 16;
    // The parity helper works on the widest legal character; narrower
    // characters are zero-extended, which leaves the XOR reduction unchanged.
    localparam int UART_MAX_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    // CSR view of the baud divisor and the frame-format bits.
    typedef logic [UART_DIV_W-1:0] uart_baud_div_t;

    typedef struct packed {
        logic parity_en;
        logic parity_odd;
        logic stop2;
    } uart_frame_fmt_t;

    // Parity bit for a character: even -> ^data, odd -> ~^data.
    function automatic logic uart_parity(input logic [UART_MAX_DATA_BITS-1:0] data,
                                         input logic                          odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Valid/ready byte channel feeding the UART transmit serializer.
// The source (CSR write path or TX FIFO) is the master, the engine the slave.
interface uart_tx_serializer_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_tx_serializer_baud_gen.sv
// Loadable bit-period down-counter. A load sets the count to div; the count
// then falls by one per cycle and holds at zero. tick is high whenever the
// count is zero, i.e. in the final cycle of each bit period.
module uart_baud_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    // Next count: reload on request, otherwise count down and stop at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = div;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - DIV_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register with synchronous reset to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: accepts characters over a valid/ready channel and
// shifts them onto tx_out_o as start, LSB-first data, optional parity and one
// or two stop bits. Bit timing comes from a CSR baud divisor
// (bit period = baud_div_i + 1 cycles). Frame settings are captured when a
// character is accepted, so CSR writes during a frame only affect later frames.
// Define UART_TX_BREAK_EN to add break_req_i, which holds the idle line low.
module uart_tx_serializer
    import uart_tx_serializer_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS,
    parameter int DIV_W     = UART_DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] baud_div_i,
    input  logic             parity_en_i,
    input  logic             parity_odd_i,
    input  logic             stop2_i,
`ifdef UART_TX_BREAK_EN
    input  logic             break_req_i,
`endif
    uart_tx_serializer_if.slave tx_if,
    output logic             tx_out_o,
    output logic             tx_busy_o,
    output logic             tx_done_o
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    uart_tx_state_t         state_q,    state_d;
    logic [DATA_BITS-1:0]   shift_q,    shift_d;
    logic [2:0]             bit_cnt_q,  bit_cnt_d;
    logic                   stop_cnt_q, stop_cnt_d;
    logic                   par_en_q,   par_en_d;
    logic                   stop2_q,    stop2_d;
    logic                   parity_q,   parity_d;
    logic [DIV_W-1:0]       div_q,      div_d;
    logic                   tx_out_q,   tx_out_d;
    logic                   ready_q,    ready_d;
    logic                   busy_q,     busy_d;
    logic                   done_q,     done_d;
`ifdef UART_TX_BREAK_EN
    logic                   brk_q,      brk_d;
    logic                   rec_q,      rec_d;
`endif

    uart_frame_fmt_t                 fmt_s;
    logic [UART_MAX_DATA_BITS-1:0]   data_ext_s;
    logic                            accept_s;
    logic                            baud_load_s;
    logic [DIV_W-1:0]                baud_val_s;
    logic                            tick_s;
    logic                            line_low_s;
    logic                            line_hold_s;

    assign fmt_s      = '{parity_en: parity_en_i, parity_odd: parity_odd_i, stop2: stop2_i};
    assign data_ext_s = UART_MAX_DATA_BITS'(tx_if.data);
    assign accept_s   = tx_if.valid && ready_q;

    uart_baud_gen #(
        .DIV_W (DIV_W)
    ) u_baud_gen (
        .clk  (clk),
        .rst  (rst),
        .load (baud_load_s),
        .div  (baud_val_s),
        .tick (tick_s)
    );

    // Frame sequencing: next state, shift register, counters and bit-timer reloads.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        stop_cnt_d  = stop_cnt_q;
        par_en_d    = par_en_q;
        stop2_d     = stop2_q;
        parity_d    = parity_q;
        div_d       = div_q;
        done_d      = 1'b0;
        baud_load_s = 1'b0;
        baud_val_s  = div_q;
        line_low_s  = 1'b0;
        line_hold_s = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    // Capture the character and the whole frame format now.
                    state_d     = START;
                    shift_d     = tx_if.data;
                    bit_cnt_d   = 3'd0;
                    stop_cnt_d  = 1'b0;
                    par_en_d    = fmt_s.parity_en;
                    stop2_d     = fmt_s.stop2;
                    parity_d    = uart_parity(data_ext_s, fmt_s.parity_odd);
                    div_d       = baud_div_i;
                    baud_load_s = 1'b1;
                    baud_val_s  = baud_div_i;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (tick_s) begin
                    state_d     = DATA;
                    baud_load_s = 1'b1;
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (tick_s) begin
                    baud_load_s = 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = shift_q >> 1;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            PARITY: begin
                if (tick_s) begin
                    state_d     = STOP;
                    baud_load_s = 1'b1;
                end else begin
                    state_d = PARITY;
                end
            end
            STOP: begin
                if (tick_s) begin
                    if (stop2_q && !stop_cnt_q) begin
                        stop_cnt_d  = 1'b1;
                        baud_load_s = 1'b1;
                    end else begin
                        // Last stop cycle: the done pulse lands in the IDLE cycle.
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef UART_TX_BREAK_EN
        // Break is only honoured between frames. When it drops, the line is
        // held high for one bit period (timed by the baud counter) before the
        // engine reports ready again.
        brk_d = 1'b0;
        rec_d = 1'b0;
        if (state_d == IDLE) begin
            if (break_req_i) begin
                brk_d = 1'b1;
            end else if (brk_q) begin
                rec_d       = 1'b1;
                baud_load_s = 1'b1;
                baud_val_s  = baud_div_i;
            end else if (rec_q && !tick_s) begin
                rec_d = 1'b1;
            end else begin
                rec_d = 1'b0;
            end
        end else begin
            brk_d = 1'b0;
        end
        line_low_s  = brk_d;
        line_hold_s = brk_d | rec_d;
`endif
    end

    // Output values for the next cycle, derived from the next state so that
    // the pins are driven straight from flops.
    always_comb begin
        tx_out_d = 1'b1;
        case (state_d)
            IDLE:    tx_out_d = ~line_low_s;
            START:   tx_out_d = 1'b0;
            DATA:    tx_out_d = shift_d[0];
            PARITY:  tx_out_d = parity_d;
            STOP:    tx_out_d = 1'b1;
            default: tx_out_d = 1'b1;
        endcase
        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE) && !line_hold_s;
    end

    // State, datapath and output registers; reset aborts any frame at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= 3'd0;
            stop_cnt_q <= 1'b0;
            par_en_q   <= 1'b0;
            stop2_q    <= 1'b0;
            parity_q   <= 1'b0;
            div_q      <= '0;
            tx_out_q   <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef UART_TX_BREAK_EN
            brk_q      <= 1'b0;
            rec_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            par_en_q   <= par_en_d;
            stop2_q    <= stop2_d;
            parity_q   <= parity_d;
            div_q      <= div_d;
            tx_out_q   <= tx_out_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef UART_TX_BREAK_EN
            brk_q      <= brk_d;
            rec_q      <= rec_d;
`endif
        end
    end

    assign tx_if.ready = ready_q;
    assign tx_out_o    = tx_out_q;
    assign tx_busy_o   = busy_q;
    assign tx_done_o   = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer. Stimulus pushes hand-written frame
// images and timed pin snapshots; one monitor captures each frame on the line
// and compares it when tx_done pulses.
`timescale 1ns/1ps
module tb_uart_tx_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] baud_div;
    logic        parity_en;
    logic        parity_odd;
    logic        stop2;
`ifdef UART_TX_BREAK_EN
    logic        break_req;
`endif
    logic        tx_out;
    logic        tx_busy;
    logic        tx_done;

    uart_tx_serializer_if #(.DATA_BITS(8)) tx_if();

    uart_tx_serializer #(.DATA_BITS(8), .DIV_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .baud_div_i   (baud_div),
        .parity_en_i  (parity_en),
        .parity_odd_i (parity_odd),
        .stop2_i      (stop2),
`ifdef UART_TX_BREAK_EN
        .break_req_i  (break_req),
`endif
        .tx_if        (tx_if),
        .tx_out_o     (tx_out),
        .tx_busy_o    (tx_busy),
        .tx_done_o    (tx_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Frame image: bit 0 is the first bit on the line (start bit).
    typedef struct {
        logic [15:0] bits;
        int          nbits;
        int          div;
        string       name;
    } frame_t;

    // Pin snapshot: {tx_out, tx_ready, tx_busy, tx_done} expected in cycle 'at'.
    typedef struct {
        int          at;
        logic [3:0]  pins;
        string       name;
    } snap_t;

    frame_t exp_q[$];
    snap_t  snap_q[$];
    int     acc_q[$];
    logic   cap[$];
    bit     stim_done = 1'b0;
    int     errors = 0;
    int     checks = 0;

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic expect_frame(input logic [15:0] bits, input int nbits, input int div,
                                input string name);
        frame_t f;
        f.bits = bits; f.nbits = nbits; f.div = div; f.name = name;
        exp_q.push_back(f);
    endtask

    task automatic expect_pins(input int at, input logic [3:0] pins, input string name);
        snap_t s;
        s.at = at; s.pins = pins; s.name = name;
        snap_q.push_back(s);
    endtask

    // Offer a byte; returns the cycle in which it was accepted. With hold set,
    // tx_valid stays high so the next call can follow back-to-back.
    task automatic send(input logic [7:0] d, input bit hold, output int acc);
        acc = -1;
        tx_if.data  = d;
        tx_if.valid = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (tx_if.ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) begin
            $display("FAIL accept_timeout: byte %h never accepted", d);
            $fatal(1, "accept timeout");
        end
        @(posedge clk);
        #1;
        if (!hold) tx_if.valid = 1'b0;
    endtask

    task automatic wait_done();
        int seen;
        seen = 0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (tx_done) begin
                seen = 1;
                break;
            end
        end
        if (seen == 0) begin
            $display("FAIL done_timeout: tx_done never pulsed");
            $fatal(1, "done timeout");
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: captures frames, checks them on tx_done, checks pin snapshots.
    initial begin : monitor
        frame_t e;
        snap_t  s;
        int     a;
        int     start_cyc;
        int     first_bad;
        int     k;
        bit     in_frame;
        bit     rdy_seen;
        in_frame = 1'b0;
        rdy_seen = 1'b0;
        start_cyc = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cap.delete();
                acc_q.delete();
                in_frame = 1'b0;
            end else begin
                if (tx_if.valid && tx_if.ready) acc_q.push_back(cyc);
                if (tx_busy) begin
                    if (!in_frame) begin
                        in_frame  = 1'b1;
                        start_cyc = cyc;
                        rdy_seen  = 1'b0;
                    end
                    cap.push_back(tx_out);
                    if (tx_if.ready) rdy_seen = 1'b1;
                end
                if (tx_done) begin
                    if (exp_q.size() == 0) begin
                        check_int("unexpected_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        a = (acc_q.size() > 0) ? acc_q.pop_front() : -100;
                        check_int({e.name, " start_cycle"}, start_cyc, a + 1);
                        check_int({e.name, " frame_len"}, cap.size(), e.nbits * (e.div + 1));
                        first_bad = -1;
                        k = 0;
                        for (int i = 0; i < e.nbits; i++) begin
                            for (int j = 0; j <= e.div; j++) begin
                                if (first_bad < 0 && (k >= cap.size() || cap[k] !== e.bits[i]))
                                    first_bad = k;
                                k++;
                            end
                        end
                        check_int({e.name, " first_bad_line_cycle"}, first_bad, -1);
                        check_int({e.name, " ready_during_frame"}, int'(rdy_seen), 0);
                        check_int({e.name, " done_cycle_out_ready_busy"},
                                  int'({tx_out, tx_if.ready, tx_busy}), 6);
                    end
                    cap.delete();
                    in_frame = 1'b0;
                end
            end
            while (snap_q.size() > 0 && snap_q[0].at <= cyc) begin
                s = snap_q.pop_front();
                if (s.at < cyc) begin
                    check_int({s.name, " missed_cycle"}, cyc, s.at);
                end else begin
                    checks++;
                    if ({tx_out, tx_if.ready, tx_busy, tx_done} !== s.pins) begin
                        errors++;
                        $display("FAIL %s: out/ready/busy/done got %b want %b", s.name,
                                 {tx_out, tx_if.ready, tx_busy, tx_done}, s.pins);
                    end
                end
            end
            if (stim_done) break;
        end
        check_int("frames_left", exp_q.size(), 0);
        check_int("snaps_left", snap_q.size(), 0);
        check_int("accepts_left", acc_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Stimulus.
    initial begin : stim
        int a;
        int a2;
        rst         = 1'b1;
        tx_if.valid = 1'b0;
        tx_if.data  = 8'h00;
        baud_div    = 16'd3;
        parity_en   = 1'b0;
        parity_odd  = 1'b0;
        stop2       = 1'b0;
`ifdef UART_TX_BREAK_EN
        break_req   = 1'b0;
`endif
        expect_pins(2, 4'b1100, "reset_state");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // T1: div=3, 8N1, 0x55.
        expect_frame(16'b000000_1_01010101_0, 10, 3, "T1_55");
        send(8'h55, 1'b0, a);
        expect_pins(a + 4,  4'b0010, "T1_last_start_cycle");
        expect_pins(a + 5,  4'b1010, "T1_first_data_cycle");
        expect_pins(a + 40, 4'b1010, "T1_last_stop_cycle");
        expect_pins(a + 41, 4'b1101, "T1_done_cycle");
        wait_done();

        // T2: div=0, even then odd parity, 0x07.
        baud_div  = 16'd0;
        parity_en = 1'b1;
        expect_frame(16'b00000_1_1_00000111_0, 11, 0, "T2_even");
        send(8'h07, 1'b0, a);
        expect_pins(a + 10, 4'b1010, "T2_even_parity_bit");
        wait_done();
        parity_odd = 1'b1;
        expect_frame(16'b00000_1_0_00000111_0, 11, 0, "T2_odd");
        send(8'h07, 1'b0, a);
        expect_pins(a + 10, 4'b0010, "T2_odd_parity_bit");
        wait_done();

        // T3: div=1, two stop bits, back-to-back with tx_valid held.
        baud_div  = 16'd1;
        parity_en = 1'b0;
        stop2     = 1'b1;
        expect_frame(16'b00000_11_10100101_0, 11, 1, "T3_A5");
        expect_frame(16'b00000_11_00111100_0, 11, 1, "T3_3C");
        send(8'hA5, 1'b1, a);
        expect_pins(a + 22, 4'b1010, "T3_second_stop_cycle");
        expect_pins(a + 23, 4'b1101, "T3_done_and_ready");
        expect_pins(a + 24, 4'b0010, "T3_second_start_bit");
        send(8'h3C, 1'b0, a2);
        wait_done();

        // T4: baud_div and format CSRs change mid-frame.
        baud_div = 16'd3;
        stop2    = 1'b0;
        expect_frame(16'b000000_1_10010110_0, 10, 3, "T4_old_div");
        send(8'h96, 1'b0, a);
        repeat (10) @(posedge clk);
        #1;
        baud_div  = 16'd7;
        parity_en = 1'b1;
        stop2     = 1'b1;
        wait_done();
        parity_en = 1'b0;
        stop2     = 1'b0;
        expect_frame(16'b000000_1_10000001_0, 10, 7, "T4_new_div");
        send(8'h81, 1'b0, a);
        wait_done();

        // Odd parity plus two stop bits at div=2.
        baud_div   = 16'd2;
        parity_en  = 1'b1;
        parity_odd = 1'b1;
        stop2      = 1'b1;
        expect_frame(16'b0000_11_1_11000011_0, 12, 2, "odd_stop2_C3");
        send(8'hC3, 1'b0, a);
        wait_done();

        // T5: reset during data bit 3 (0x35 has bit 3 = 0).
        baud_div   = 16'd3;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        stop2      = 1'b0;
        send(8'h35, 1'b0, a);
        expect_pins(a + 18, 4'b0010, "T5_in_data_bit3");
        expect_pins(a + 19, 4'b1100, "T5_after_reset");
        expect_pins(a + 20, 4'b1100, "T5_no_done_pulse");
        expect_pins(a + 21, 4'b1100, "T5_still_idle");
        repeat (17) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

`ifdef UART_TX_BREAK_EN
        // T6: break for 20 cycles at div=3.
        a = cyc;
        expect_pins(a + 1,  4'b0000, "T6_break_low");
        expect_pins(a + 20, 4'b0000, "T6_break_last");
        expect_pins(a + 21, 4'b1000, "T6_recovery_first");
        expect_pins(a + 24, 4'b1000, "T6_recovery_last");
        expect_pins(a + 25, 4'b1100, "T6_ready_again");
        break_req = 1'b1;
        repeat (20) @(posedge clk);
        #1 break_req = 1'b0;
        repeat (8) @(posedge clk);
        #1;
`endif

        repeat (5) @(posedge clk);
        #1 stim_done = 1'b1;
    end

endmodule
